// File: rtl/nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Purpose:
//   This block adds two WIDTH-bit operands using a single external 4-bit adder.
//   It processes one nibble per clock, starting with the least significant
//   nibble. On an accepted start it latches both operands and the carry-in.
//   It then steps through the NIB nibbles, sending each pair of operand
//   nibbles and the running carry to the adder. It captures the adder's sum
//   and carry-out on every step. After the last step it pulses done for one
//   cycle.
//
//   WIDTH must be a multiple of 4 and at least 8.
//
// Ports:
//   clk       in   1      clock, rising-edge
//   rst       in   1      synchronous, active-high reset (wins over start)
//   start     in   1      request, accepted only while idle
//   a, b      in   WIDTH  operands, sampled on an accepted start
//   cin       in   1      carry-in, sampled on an accepted start
//   busy      out  1      high while an operation is running or completing
//   done      out  1      one-cycle pulse, sum/cout are valid
//   sum       out  WIDTH  result, holds until the next accepted start
//   cout      out  1      final carry-out, holds like sum
//   add_a     out  4      to adder: current nibble of latched A (0 when not running)
//   add_b     out  4      to adder: current nibble of latched B (0 when not running)
//   add_cin   out  1      to adder: running carry (0 when not running)
//   add_sum   in   4      from adder: combinational nibble sum
//   add_cout  in   1      from adder: combinational carry-out
// ----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands and the result are held as nibble arrays so that the step
    // index selects a nibble directly.
    logic [NIB-1:0][3:0] a_nib;
    logic [NIB-1:0][3:0] b_nib;
    logic [NIB-1:0][3:0] sum_nib;
    logic                carry;
    logic                cout_r;
    logic [IDX_W-1:0]    idx;
    logic                last_step;

    assign last_step = (idx == IDX_W'(NIB - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Step counter, carry chain and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry   <= 1'b0;
            sum_nib <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        carry   <= cin;
                        sum_nib <= '0;
                        cout_r  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_nib[idx] <= add_sum;
                    carry        <= add_cout;
                    if (last_step) begin
                        // The counter stays on the last nibble; it is
                        // cleared again on the next accepted start.
                        cout_r <= add_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The operand latches are pure data and are not reset. They are only
    // read while RUN, and RUN is always entered through a fresh load.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_nib <= a;
            b_nib <= b;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The adder inputs are forced to zero outside RUN. This stops the
    // shared adder from seeing stale operands.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_nib[idx];
            add_b   = b_nib[idx];
            add_cin = carry;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign sum  = sum_nib;
    assign cout = cout_r;

endmodule
